// File: rtl/mem_move_engine_if.sv
// Bundle between mem_move_engine and its environment: the controller
// request/status side plus the data-memory bus the engine owns while busy.
// The slave modport is the engine's view; master is the controller+memory view.
interface mem_move_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] len;
    logic [DW-1:0] fill_val;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr_en;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;

    modport master (
        output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_wr_en, mem_rd
    );

    modport slave (
        input  start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_wr_en, mem_rd
    );
endinterface

// File: rtl/mem_move_engine.sv
// Block-move / fill sequencer in front of the data memory.
// Copy is overlap-safe (runs backward when dst lies inside [src, src+len)),
// 2 cycles per byte (read, write); fill is 1 cycle per byte.
// All outputs are registered; next values are computed together with the
// next state so the memory bus never depends combinationally on inputs.
// Optional feature macro: MEM_MOVE_CHECKSUM_EN adds output csum, the
// mod-2**DW sum of every byte written during the current operation.
module mem_move_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_move_engine_if.slave     bus
`ifdef MEM_MOVE_CHECKSUM_EN
    ,
    output logic [DW-1:0]        csum
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          back_q, back_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] off_q, off_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
`ifdef MEM_MOVE_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    // Direction decision for a new request: src+len is taken one bit wider
    // so a source range running past the top of memory is not wrapped here.
    logic [AW:0]   src_end;
    logic          start_back;
    logic [AW-1:0] start_off;
    logic [AW-1:0] off_step;

    assign src_end    = {1'b0, bus.src_addr} + {1'b0, bus.len};
    assign start_back = ~bus.mode && (bus.dst_addr > bus.src_addr)
                        && ({1'b0, bus.dst_addr} < src_end);
    assign start_off  = start_back ? bus.len - AW'(1) : '0;
    assign off_step   = back_q ? off_q - AW'(1) : off_q + AW'(1);

    // State, operands and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            back_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
`ifdef MEM_MOVE_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            back_q  <= back_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`ifdef MEM_MOVE_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next state plus the output values for the state being entered.
    // wdata_q doubles as the read-hold register between RD and WR.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        back_d  = back_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        fill_d  = fill_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
`ifdef MEM_MOVE_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    src_d  = bus.src_addr;
                    dst_d  = bus.dst_addr;
                    cnt_d  = bus.len;
                    fill_d = bus.fill_val;
                    back_d = start_back;
                    off_d  = start_off;
                    busy_d = 1'b1;
`ifdef MEM_MOVE_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (bus.len == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (!bus.mode) begin
                        state_d = S_RD;
                        rd_d    = 1'b1;
                        addr_d  = bus.src_addr + start_off;
                    end else begin
                        state_d = S_WR;
                        wr_d    = 1'b1;
                        addr_d  = bus.dst_addr + start_off;
                        wdata_d = bus.fill_val;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
                wr_d    = 1'b1;
                addr_d  = dst_q + off_q;
                wdata_d = bus.mem_rdata;
            end
            S_WR: begin
                cnt_d = cnt_q - AW'(1);
                off_d = off_step;
`ifdef MEM_MOVE_CHECKSUM_EN
                csum_d = csum_q + wdata_q;
`endif
                if (cnt_q == AW'(1)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else if (!mode_q) begin
                    state_d = S_RD;
                    rd_d    = 1'b1;
                    addr_d  = src_q + off_step;
                end else begin
                    wr_d    = 1'b1;
                    addr_d  = dst_q + off_step;
                    wdata_d = fill_q;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr_en = wr_q;
    assign bus.mem_rd    = rd_q;
`ifdef MEM_MOVE_CHECKSUM_EN
    assign csum = csum_q;
`endif
endmodule

// File: tb/tb_mem_move_engine.sv
// Bench for mem_move_engine: a 256x8 memory model, a per-cycle expectation
// queue built from the move/fill rules, and a negedge compare process.
// Honours MEM_MOVE_CHECKSUM_EN the same way the design does.
module tb_mem_move_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_move_engine_if #(.AW(8), .DW(8)) bus();
`ifdef MEM_MOVE_CHECKSUM_EN
    logic [7:0] csum;
`endif

    mem_move_engine #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
`ifdef MEM_MOVE_CHECKSUM_EN
        ,
        .csum  (csum)
`endif
    );

    typedef struct {
        bit         busy;
        bit         done;
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        bit         first;
        bit         chk_csum;
        logic [7:0] csum;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem       [256];
    logic [7:0] model_mem [256];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         obs_done_cyc = 0;
    logic [7:0] obs_first_wr = 8'h00;
    logic       pend_wr = 1'b0;
    logic [7:0] pend_addr = 8'h00;
    logic [7:0] pend_data = 8'h00;
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'h00;
    logic [7:0] tb_data = 8'h00;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array and committed-write model memory.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr]       <= tb_data;
            model_mem[tb_addr] <= tb_data;
        end
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (pend_wr && !rst) model_mem[pend_addr] <= pend_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk(bit b, bit dn, bit r, bit w, logic [7:0] a,
                                logic [7:0] dt, bit f, bit cc, logic [7:0] cs);
        exp_t e;
        e.busy = b; e.done = dn; e.rd = r; e.wr = w; e.addr = a;
        e.data = dt; e.first = f; e.chk_csum = cc; e.csum = cs;
        return e;
    endfunction

    // Expected bus activity for one accepted request, byte by byte in the
    // order memmove would touch them, reading from a scratch memory image.
    task automatic push_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] fv);
        logic [7:0] tmp [256];
        logic [7:0] sum, off, v, a;
        bit back, first_ent, first_wr;
        for (int i = 0; i < 256; i++) tmp[i] = model_mem[i];
        sum = 8'h00; first_ent = 1; first_wr = 1;
        back = (m == 1'b0) && (d > s) && (int'(d) < int'(s) + int'(l));
        for (int k = 0; k < int'(l); k++) begin
            off = back ? 8'(int'(l) - 1 - k) : 8'(k);
            if (!m) begin
                a = 8'(s + off);
                v = tmp[a];
                expq.push_back(mk(1, 0, 1, 0, a, 8'h00, 0, first_ent, 8'h00));
                first_ent = 0;
            end else begin
                v = fv;
            end
            a = 8'(d + off);
            expq.push_back(mk(1, 0, 0, 1, a, v, first_wr, first_ent, 8'h00));
            first_ent = 0; first_wr = 0;
            tmp[a] = v;
            sum = sum + v;
        end
        expq.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 1, sum));
    endtask

    // Per-cycle compare of every DUT output against the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst || expq.size() == 0) e = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        else e = expq.pop_front();
        chk("busy", bus.busy, e.busy);
        chk("done", bus.done, e.done);
        chk("mem_rd", bus.mem_rd, e.rd);
        chk("mem_wr_en", bus.mem_wr_en, e.wr);
        chk("rd_wr_exclusive", bus.mem_rd & bus.mem_wr_en, 0);
        if (e.rd || e.wr || rst) chk("mem_addr", bus.mem_addr, e.addr);
        if (e.wr || rst) chk("mem_wdata", bus.mem_wdata, e.data);
`ifdef MEM_MOVE_CHECKSUM_EN
        if (e.chk_csum) chk("csum", csum, e.csum);
`endif
        if (e.first) obs_first_wr <= bus.mem_addr;
        if (bus.done) obs_done_cyc <= cyc;
        pend_wr   <= e.wr && !rst;
        pend_addr <= e.addr;
        pend_data <= e.data;
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        tb_addr = a; tb_data = v; tb_we = 1'b1;
        @(negedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        for (n = 0; n < 300 && expq.size() != 0; n++) @(negedge clk);
        chk("op_completes_in_time", expq.size(), 0);
        expq.delete();
    endtask

    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] fv, input bit pulse);
        wait_empty();
        @(negedge clk); #1;
        bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
        bus.len = l; bus.fill_val = fv;
        t0 = cyc;
        push_op(m, s, d, l, fv);
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.mode = 1'($urandom); bus.src_addr = 8'($urandom); bus.dst_addr = 8'($urandom);
        bus.len = 8'($urandom); bus.fill_val = 8'($urandom);
        if (pulse && expq.size() >= 3) begin
            @(negedge clk); #1;
            bus.start = 1'b1;
            @(negedge clk); #1;
            bus.start = 1'b0;
        end
        wait_empty();
        @(negedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = 8'h00;
        bus.dst_addr = 8'h00; bus.len = 8'h00; bus.fill_val = 8'h00;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_wr_en", bus.mem_wr_en, 0);
        chk("reset_rd", bus.mem_rd, 0);
        chk("reset_addr", bus.mem_addr, 0);
        chk("reset_wdata", bus.mem_wdata, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
        preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03);
        preload(8'h30, 8'h11); preload(8'h31, 8'h22);
        preload(8'h32, 8'h33); preload(8'h33, 8'h44);

        // Fill 4 x A5 at 0x10
        run_op(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 0);
        chk("fill_latency", obs_done_cyc - t0, 5);
        chk("fill_mem10", mem[8'h10], 8'hA5);
        chk("fill_mem13", mem[8'h13], 8'hA5);
        chk("fill_mem0f_untouched", mem[8'h0F], 8'h00);
        chk("fill_mem14_untouched", mem[8'h14], 8'h00);
`ifdef MEM_MOVE_CHECKSUM_EN
        chk("fill_csum_literal", csum, 8'h94);
`endif
        // Forward copy 0x20 -> 0x40
        run_op(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 0);
        chk("fwd_latency", obs_done_cyc - t0, 7);
        chk("fwd_mem40", mem[8'h40], 8'h01);
        chk("fwd_mem41", mem[8'h41], 8'h02);
        chk("fwd_mem42", mem[8'h42], 8'h03);
        // Overlapping backward copy 0x30 -> 0x31
        run_op(1'b0, 8'h30, 8'h31, 8'd4, 8'h00, 0);
        chk("bwd_first_write_addr", obs_first_wr, 8'h34);
        chk("bwd_mem31", mem[8'h31], 8'h11);
        chk("bwd_mem32", mem[8'h32], 8'h22);
        chk("bwd_mem33", mem[8'h33], 8'h33);
        chk("bwd_mem34", mem[8'h34], 8'h44);
        // Wrapping fill
        run_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 0);
        chk("wrap_memfe", mem[8'hFE], 8'h5A);
        chk("wrap_mem01", mem[8'h01], 8'h5A);
        chk("wrap_mem02_untouched", mem[8'h02], 8'h00);
        chk("wrap_memfd_untouched", mem[8'hFD], 8'h00);
        // Zero length
        run_op(1'b1, 8'h00, 8'h60, 8'd0, 8'hFF, 0);
        chk("len0_latency", obs_done_cyc - t0, 1);
        chk("len0_mem60_untouched", mem[8'h60], 8'h00);
        // Start pulsed while busy is ignored
        run_op(1'b1, 8'h00, 8'h70, 8'd6, 8'h3C, 1);
        chk("busy_start_mem75", mem[8'h75], 8'h3C);

        // Reset after 2 of 4 fill writes
        @(negedge clk); #1;
        bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 8'h50;
        bus.len = 8'd4; bus.fill_val = 8'h77;
        t0 = cyc;
        push_op(1'b1, 8'h00, 8'h50, 8'd4, 8'h77);
        @(negedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        expq.delete();
        #1;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_wr_en", bus.mem_wr_en, 0);
        chk("midreset_addr", bus.mem_addr, 0);
        chk("midreset_wdata", bus.mem_wdata, 0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midreset_mem51_written", mem[8'h51], 8'h77);
        chk("midreset_mem52_unwritten", mem[8'h52], 8'h00);
        chk("midreset_mem53_unwritten", mem[8'h53], 8'h00);

        // Randomized operations over a random memory image
        for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            logic       m;
            logic [7:0] s, d, l;
            m = 1'($urandom_range(0, 1));
            s = 8'($urandom);
            d = ($urandom_range(0, 1) != 0) ? 8'(s + 8'($urandom_range(0, 6)) - 8'd3)
                                              : 8'($urandom);
            l = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
            run_op(m, s, d, l, 8'($urandom), bit'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        for (int a = 0; a < 256; a++) chk("final_mem", mem[a], model_mem[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
